// File: rtl/packet_sink.sv
// Two-phase req/ack flit sink: frames FLITS flits per packet on the head bit and counts packets and framing errors.
// Optional macro PACKET_SINK_ACK_DELAY_EN delays the ack transition by ACK_DELAY cycles after capture.
module packet_sink #(
  parameter int ID        = 0,
  parameter int FLITS     = 8,
  parameter int SIZE      = 8,
  parameter int ACK_DELAY = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic [SIZE-1:0]       data,
  input  logic                  hold,
  output logic                  ack,
  output logic                  packet_valid,
  output logic [FLITS*SIZE-1:0] packet_data,
  output logic [7:0]            packet_count,
  output logic                  err_orphan,
  output logic                  err_trunc,
  output logic [7:0]            err_count
);

  localparam int IW = (FLITS > 1) ? $clog2(FLITS) : 1;

  if (FLITS < 1 || FLITS > 255 || SIZE < 2 || ACK_DELAY < 1 || ACK_DELAY > 255 || ID < 0) begin : g_param_err
    $error("packet_sink %0d: parameter out of range", ID);
  end

  typedef enum logic {IDLE, BODY} state_t;

  state_t                      state;
  logic                        req_old;
  logic [IW-1:0]               idx;
  logic [FLITS-1:0][SIZE-1:0]  flit_buf;
  logic [FLITS-1:0][SIZE-1:0]  pkt_next;
  logic [IW-1:0]               wsel;
  logic                        head, accept, done, busy;

  assign head   = data[SIZE-1];
  assign accept = (req != req_old) && !hold && !busy;
  // A head always lands in slot 0; idx is 0 while IDLE, so only BODY bodies use idx.
  assign wsel   = (state == BODY && !head) ? idx : '0;
  assign done   = (state == IDLE) ? (head && (FLITS == 1))
                                  : (!head && (idx == IW'(FLITS-1)));

  // Buffer with the incoming flit merged in, so a completed packet loads in one shot.
  for (genvar k = 0; k < FLITS; k++) begin : g_slot
    assign pkt_next[k] = (wsel == IW'(k)) ? data : flit_buf[k];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      req_old      <= 1'b0;
      flit_buf     <= '0;
      packet_data  <= '0;
      packet_valid <= 1'b0;
      packet_count <= 8'd0;
      err_orphan   <= 1'b0;
      err_trunc    <= 1'b0;
      err_count    <= 8'd0;
    end else begin
      packet_valid <= 1'b0;
      err_orphan   <= 1'b0;
      err_trunc    <= 1'b0;
      if (accept) begin
        req_old <= req;
        if (state == IDLE && !head) begin
          err_orphan <= 1'b1;
          if (err_count != 8'hff) err_count <= err_count + 8'd1;
        end else begin
          flit_buf <= pkt_next;
          if (state == BODY && head) begin
            err_trunc <= 1'b1;
            if (err_count != 8'hff) err_count <= err_count + 8'd1;
          end
          if (done) begin
            packet_data  <= pkt_next;
            packet_valid <= 1'b1;
            packet_count <= packet_count + 8'd1;
            state        <= IDLE;
            idx          <= '0;
          end else begin
            state <= BODY;
            idx   <= head ? IW'(1) : idx + 1'b1;
          end
        end
      end
    end
  end

`ifdef PACKET_SINK_ACK_DELAY_EN
  logic [7:0] dly_cnt;
  assign busy = (dly_cnt != 8'd0);

  // Ack flips on the edge where the counter reaches zero, ACK_DELAY edges after capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dly_cnt <= 8'd0;
      ack     <= 1'b0;
    end else if (accept) begin
      dly_cnt <= 8'(ACK_DELAY);
    end else if (busy) begin
      dly_cnt <= dly_cnt - 8'd1;
      if (dly_cnt == 8'd1) ack <= ~ack;
    end
  end
`else
  assign busy = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       ack <= 1'b0;
    else if (accept) ack <= ~ack;
  end
`endif

endmodule
